// File: rtl/ps2_kbd_pkg.sv
// Shared FSM state type, PS/2 byte constants and key_word layout for the keyboard receiver.
// PS2_ASCII_EN adds the scan-set-2 to ASCII translation function.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  localparam int KW_VALID = 15;
  localparam int KW_BRK   = 14;
  localparam int KW_EXT   = 13;
  localparam int KW_SHIFT = 12;
  localparam int KW_OVF   = 11;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic       shift;
    logic [7:0] code;
  } key_evt_t;

`ifdef PS2_ASCII_EN
  // Unmapped scan codes return 00h so the caller can suppress them.
  function automatic logic [7:0] ps2_ascii(input logic [7:0] scan, input logic shift);
    logic [7:0] lower;
    lower = 8'h00;
    case (scan)
      8'h1C: lower = 8'h61; 8'h32: lower = 8'h62; 8'h21: lower = 8'h63; 8'h23: lower = 8'h64;
      8'h24: lower = 8'h65; 8'h2B: lower = 8'h66; 8'h34: lower = 8'h67; 8'h33: lower = 8'h68;
      8'h43: lower = 8'h69; 8'h3B: lower = 8'h6A; 8'h42: lower = 8'h6B; 8'h4B: lower = 8'h6C;
      8'h3A: lower = 8'h6D; 8'h31: lower = 8'h6E; 8'h44: lower = 8'h6F; 8'h4D: lower = 8'h70;
      8'h15: lower = 8'h71; 8'h2D: lower = 8'h72; 8'h1B: lower = 8'h73; 8'h2C: lower = 8'h74;
      8'h3C: lower = 8'h75; 8'h2A: lower = 8'h76; 8'h1D: lower = 8'h77; 8'h22: lower = 8'h78;
      8'h35: lower = 8'h79; 8'h1A: lower = 8'h7A;
      8'h45: lower = 8'h30; 8'h16: lower = 8'h31; 8'h1E: lower = 8'h32; 8'h26: lower = 8'h33;
      8'h25: lower = 8'h34; 8'h2E: lower = 8'h35; 8'h36: lower = 8'h36; 8'h3D: lower = 8'h37;
      8'h3E: lower = 8'h38; 8'h46: lower = 8'h39;
      8'h29: lower = 8'h20; 8'h5A: lower = 8'h0D; 8'h66: lower = 8'h08;
      default: lower = 8'h00;
    endcase
    if (shift && (lower >= 8'h61) && (lower <= 8'h7A)) begin
      return lower - 8'h20;
    end
    return lower;
  endfunction
`endif

endpackage

// File: rtl/ps2_kbd_rx_fifo_if.sv
// MCU-side port of the PS/2 receiver: head-event word, status and the pop strobe.
interface ps2_kbd_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rd_en;
  logic [15:0]   key_word;
  logic          key_valid;
  logic [CW-1:0] fifo_count;
  logic          frame_err;

  modport master (output rd_en, input key_word, input key_valid, input fifo_count, input frame_err);
  modport slave  (input rd_en, output key_word, output key_valid, output fifo_count, output frame_err);
endinterface

// File: rtl/ps2_kbd_fifo.sv
// Synchronous FIFO with a registered head word, occupancy count and sticky overflow.
// Shared between the keyboard and UART receive paths.
module ps2_kbd_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   empty_o,
  output logic                   overflow_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             ovf_q, ovf_d;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    head_d   = head_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(do_pop);

    if (push_i && !do_push) begin
      ovf_d = 1'b1;
    end else if (do_pop && (count_d == '0)) begin
      ovf_d = 1'b0;
    end

    // Head tracks the post-update oldest entry so it is valid the cycle after a push.
    if (count_d == '0) begin
      head_d = '0;
    end else if (do_pop) begin
      head_d = (count_q == CW'(1)) ? wdata_i : mem_q[rd_ptr_d];
    end else if (empty) begin
      head_d = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
    end
  end

  assign head_o     = head_q;
  assign empty_o    = empty;
  assign overflow_o = ovf_q;
  assign count_o    = count_q;

endmodule

// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard front end: pin sync and clock filter, frame deframer, E0/F0 and Shift decode, event FIFO.
// Define PS2_ASCII_EN to translate scan codes to ASCII and queue make events only.
module ps2_kbd_rx_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int CLK_FREQUENCY = 12_000_000,
  parameter int TIMEOUT_US    = 1000,
  parameter int FILTER_LEN    = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ps2k_clk,
  input  logic               ps2k_data,
  ps2_kbd_rx_fifo_if.slave   mcu
);
  localparam int TO_CYCLES = CLK_FREQUENCY / 1_000_000 * TIMEOUT_US;
  localparam int TOW       = $clog2(TO_CYCLES + 1);
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;

  // Input synchronisers and ps2k_clk glitch filter; lines idle high.
  logic                  clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  filt_q, fall_q, bit_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      hist_q   <= '1;
      filt_q   <= 1'b1;
      fall_q   <= 1'b0;
      bit_q    <= 1'b1;
    end else begin
      clk_s1_q <= ps2k_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2k_data;
      dat_s2_q <= dat_s1_q;
      hist_q   <= {hist_q[FILTER_LEN-2:0], clk_s2_q};
      if (&hist_q)       filt_q <= 1'b1;
      else if (~|hist_q) filt_q <= 1'b0;
      fall_q   <= filt_q && ~|hist_q;
      bit_q    <= dat_s2_q;
    end
  end

  // Frame deframer.
  ps2_state_e     state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     sr_q, sr_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic           err_d, done_d;
  logic           frame_err_q, byte_done_q;
  logic [7:0]     byte_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    err_d     = 1'b0;
    done_d    = 1'b0;
    if ((state_q == IDLE) || fall_q) to_cnt_d = '0;
    else                             to_cnt_d = to_cnt_q + 1'b1;

    if ((state_q != IDLE) && !fall_q && (to_cnt_q == TOW'(TO_CYCLES - 1))) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (fall_q) begin
      unique case (state_q)
        IDLE: begin
          if (!bit_q) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          sr_d      = {bit_q, sr_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          if (^{sr_q, bit_q}) begin
            state_d = STOP;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
        STOP: begin
          state_d = IDLE;
          if (bit_q) done_d = 1'b1;
          else       err_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      to_cnt_q    <= '0;
      frame_err_q <= 1'b0;
      byte_done_q <= 1'b0;
      byte_q      <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= err_d;
      byte_done_q <= done_d;
      if (done_d) byte_q <= sr_q;
    end
  end

  // Prefix and Shift decode; the event is formed before Shift is updated.
  logic     ext_q, ext_d, brk_q, brk_d, shift_q, shift_d, push;
  key_evt_t evt;

  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    shift_d = shift_q;
    push    = 1'b0;
    evt     = {brk_q, ext_q, shift_q, byte_q};
    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_done_q) begin
      if (byte_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (byte_q == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
`ifdef PS2_ASCII_EN
        evt.code = ps2_ascii(byte_q, shift_q);
        push     = !brk_q && (evt.code != 8'h00);
`else
        push     = 1'b1;
`endif
        if ((byte_q == PS2_LSHIFT) || (byte_q == PS2_RSHIFT)) shift_d = !brk_q;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      shift_q <= shift_d;
    end
  end

  // Event FIFO and MCU-facing word.
  key_evt_t      fifo_head;
  logic          fifo_empty, fifo_ovf;
  logic [CW-1:0] fifo_cnt;

  ps2_kbd_fifo #(
    .WIDTH ($bits(key_evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (push),
    .wdata_i    (evt),
    .pop_i      (mcu.rd_en),
    .head_o     (fifo_head),
    .empty_o    (fifo_empty),
    .overflow_o (fifo_ovf),
    .count_o    (fifo_cnt)
  );

  always_comb begin
    mcu.key_word           = '0;
    mcu.key_word[KW_VALID] = !fifo_empty;
    mcu.key_word[KW_BRK]   = fifo_head.brk;
    mcu.key_word[KW_EXT]   = fifo_head.ext;
    mcu.key_word[KW_SHIFT] = fifo_head.shift;
    mcu.key_word[KW_OVF]   = fifo_ovf;
    mcu.key_word[7:0]      = fifo_head.code;
  end

  assign mcu.key_valid  = !fifo_empty;
  assign mcu.fifo_count = fifo_cnt;
  assign mcu.frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Self-checking bench: PS/2 frames at 80 clk per bit against a queue-based event model.
module tb_ps2_kbd_rx_fifo;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ps2k_clk = 1'b1;
  logic ps2k_data = 1'b1;

  always #5 clk = ~clk;

  ps2_kbd_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) mcu ();

  ps2_kbd_rx_fifo #(
    .CLK_FREQUENCY (1_000_000),
    .TIMEOUT_US    (1000),
    .FILTER_LEN    (4),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2k_clk  (ps2k_clk),
    .ps2k_data (ps2k_data),
    .mcu       (mcu)
  );

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  int err_exp  = 0;

  logic [15:0] q[$];
  bit m_ext, m_brk, m_shift, m_ovf;

  always @(negedge clk) if (mcu.frame_err === 1'b1) err_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_word();
    if (q.size() == 0) return {4'b0000, m_ovf, 11'd0};
    return {q[0][15:12], m_ovf, q[0][10:0]};
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".word"},  32'(mcu.key_word), 32'(exp_word()));
    check({tag, ".count"}, 32'(mcu.fifo_count), 32'(q.size()));
    check({tag, ".valid"}, 32'(mcu.key_valid), 32'(q.size() != 0));
    check({tag, ".errs"},  32'(err_seen), 32'(err_exp));
  endtask

  task automatic model_reset();
    q.delete();
    m_ext = 0; m_brk = 0; m_shift = 0; m_ovf = 0;
  endtask

  task automatic model_push(input logic [15:0] w);
    if (q.size() == DEPTH) m_ovf = 1;
    else q.push_back(w);
  endtask

  task automatic model_pop();
    if (q.size() > 0) begin
      void'(q.pop_front());
      if (q.size() == 0) m_ovf = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      model_push({1'b1, m_brk, m_ext, m_shift, 4'b0000, b});
      if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  // One bit cell: data set mid-high, clock low 40 clk, high 40 clk.
  task automatic ps2_bit(input logic b, input bit pop_here);
    ps2k_data = b;
    repeat (20) @(negedge clk);
    ps2k_clk = 1'b0;
    if (pop_here) begin
      // rd_en lands on the cycle the stop bit's event is written.
      repeat (8) @(negedge clk);
      mcu.rd_en = 1'b1;
      @(negedge clk);
      mcu.rd_en = 1'b0;
      repeat (31) @(negedge clk);
    end else begin
      repeat (40) @(negedge clk);
    end
    ps2k_clk = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit pop_at_stop);
    logic [10:0] bits;
    bits = {1'b1, (bad_par ? (^b) : (~^b)), b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i], pop_at_stop && (i == 10));
    ps2k_data = 1'b1;
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b, input bit bad_par);
    send_frame(b, bad_par, 11, 1'b0);
    if (bad_par) begin
      err_exp++;
      m_ext = 0;
      m_brk = 0;
    end else begin
      model_byte(b);
    end
    $display("frame %s: byte=%02h bad_parity=%0d count=%0d word=%04h", tag, b, bad_par, mcu.fifo_count, mcu.key_word);
    check_outputs(tag);
  endtask

  task automatic pop_evt(input string tag);
    @(negedge clk);
    mcu.rd_en = 1'b1;
    @(negedge clk);
    mcu.rd_en = 1'b0;
    model_pop();
    repeat (2) @(negedge clk);
    $display("pop   %s: count=%0d word=%04h", tag, mcu.fifo_count, mcu.key_word);
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    mcu.rd_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

`ifdef PS2_ASCII_EN
    send_frame(8'h1C, 0, 11, 0);
    send_frame(8'hF0, 0, 11, 0);
    send_frame(8'h1C, 0, 11, 0);
    check("ascii_a.word", 32'(mcu.key_word), 32'h8061);
    check("ascii_a.count", 32'(mcu.fifo_count), 32'd1);
    @(negedge clk); mcu.rd_en = 1'b1; @(negedge clk); mcu.rd_en = 1'b0;
    send_frame(8'h12, 0, 11, 0);
    send_frame(8'h1C, 0, 11, 0);
    send_frame(8'hF0, 0, 11, 0);
    send_frame(8'h1C, 0, 11, 0);
    send_frame(8'hF0, 0, 11, 0);
    send_frame(8'h12, 0, 11, 0);
    check("ascii_A.word", 32'(mcu.key_word), 32'h9041);
    check("ascii_A.count", 32'(mcu.fifo_count), 32'd1);
    $display("frame ascii: word=%04h", mcu.key_word);
`else
    // Raw make/break
    send_byte("raw_make", 8'h1C, 0);
    check("raw_make.const", 32'(mcu.key_word), 32'h801C);
    send_byte("raw_f0", 8'hF0, 0);
    send_byte("raw_brk", 8'h1C, 0);
    pop_evt("raw_pop1");
    check("raw_pop1.const", 32'(mcu.key_word), 32'hC01C);
    pop_evt("raw_pop2");
    pop_evt("pop_empty");

    // Extended break then plain make
    send_byte("ext_e0", 8'hE0, 0);
    send_byte("ext_f0", 8'hF0, 0);
    send_byte("ext_75", 8'h75, 0);
    check("ext_75.const", 32'(mcu.key_word), 32'hE075);
    pop_evt("ext_pop");
    send_byte("plain_75", 8'h75, 0);
    check("plain_75.const", 32'(mcu.key_word), 32'h8075);
    pop_evt("plain_pop");

    // Parity error
    send_byte("bad_parity", 8'h1C, 1);
    send_byte("after_parity", 8'h32, 0);
    check("after_parity.const", 32'(mcu.key_word), 32'h8032);
    pop_evt("parity_pop");

    // Timeout after 5 data bits
    send_frame(8'h1C, 0, 6, 0);
    repeat (1100) @(negedge clk);
    err_exp++;
    m_ext = 0; m_brk = 0;
    $display("timeout: errs=%0d", err_seen);
    check_outputs("timeout");
    send_byte("after_timeout", 8'h1C, 0);

    // Reset mid-frame
    send_frame(8'h55, 0, 4, 0);
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    $display("reset mid-frame: count=%0d", mcu.fifo_count);
    check_outputs("midreset");
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    send_byte("after_reset", 8'h1C, 0);
    pop_evt("reset_pop");

    // Overflow at depth, ordered drain, then simultaneous push/pop when full
    for (int i = 1; i <= 9; i++) send_byte("ovf_fill", 8'(8'h20 + i), 0);
    check("ovf_bit", 32'(mcu.key_word[11]), 32'd1);
    for (int i = 0; i < 8; i++) pop_evt("ovf_drain");
    check("ovf_cleared", 32'(mcu.key_word[11]), 32'd0);
    for (int i = 1; i <= 8; i++) send_byte("full_fill", 8'(8'h30 + i), 0);
    send_frame(8'h3A, 0, 11, 1);
    model_pop();
    model_byte(8'h3A);
    $display("frame push+pop at full: count=%0d word=%04h", mcu.fifo_count, mcu.key_word);
    check_outputs("pushpop_full");
    while (q.size() > 0) pop_evt("full_drain");

    // Random byte stream with prefixes, Shift and occasional parity errors
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = 8'h12;
        3:       b = 8'h59;
        default: b = 8'($urandom_range(1, 127));
      endcase
      send_byte("rand", b, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 2) == 0) pop_evt("rand_pop");
    end
    while (q.size() > 0) pop_evt("final_drain");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
